// File: rtl/sram1rw_mwp.sv
// Parametrised 1RW SRAM behavioural model with per-group write mask, optional
// output register, read-valid strobe and a post-reset zero-fill sweep.
module sram1rw_mwp #(
  parameter int unsigned WIDTH     = 48,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned MASK_GRAN = 8,
  parameter int unsigned OUT_REG   = 0
) (
  input  logic                         CE,
  input  logic                         RSTB,
  input  logic                         CSB,
  input  logic                         WEB,
  input  logic                         OEB,
  input  logic [ADDR_W-1:0]            A,
  input  logic [WIDTH-1:0]             I,
  input  logic [WIDTH/MASK_GRAN-1:0]   WMASK,
  output logic [WIDTH-1:0]             O,
  output logic                         VALID,
  output logic                         BUSY
);

  localparam int unsigned NGRP = WIDTH / MASK_GRAN;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L = ADDR_W'(DEPTH - 1);

  if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
    $error("sram1rw_mwp: WIDTH must be a multiple of MASK_GRAN");
  end
  if (DEPTH < 2 || (64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_depth
    $error("sram1rw_mwp: DEPTH must be >= 2 and fit in ADDR_W bits");
  end

  typedef enum logic {ST_FILL = 1'b0, ST_RUN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [WIDTH-1:0]    o_q;
  logic                valid_q;

  logic [WIDTH-1:0]    mem [DEPTH];

  logic                in_range;
  logic                rd_en;
  logic                wr_en;
  logic                fill_we;
  logic [WIDTH-1:0]    bit_mask;
  logic [WIDTH-1:0]    rd_word;

  assign in_range = ({1'b0, A} < DEPTH_L);
  assign rd_en    = (state_q == ST_RUN) & ~CSB & ~OEB;
  assign wr_en    = (state_q == ST_RUN) & ~CSB & ~WEB & in_range;
  assign fill_we  = (state_q == ST_FILL) & RSTB;
  assign rd_word  = in_range ? mem[A] : '0;

  // Expand the group mask to a per-bit mask
  always_comb begin
    bit_mask = '0;
    for (int unsigned g = 0; g < NGRP; g++) begin
      bit_mask[g*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{WMASK[g]}};
    end
  end

  always_ff @(posedge CE or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Sweep one word per edge; the edge that clears the last word opens the array
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_FILL: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_L) begin
          state_d = ST_RUN;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Array has no reset; read-first falls out of non-blocking update
  always_ff @(posedge CE) begin
    if (fill_we) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      mem[A] <= (mem[A] & ~bit_mask) | (I & bit_mask);
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic             p_vld_q;
    logic [WIDTH-1:0] p_dat_q;

    always_ff @(posedge CE or negedge RSTB) begin
      if (!RSTB) begin
        p_vld_q <= 1'b0;
        p_dat_q <= '0;
        o_q     <= '0;
        valid_q <= 1'b0;
      end else begin
        p_vld_q <= rd_en;
        if (rd_en) begin
          p_dat_q <= rd_word;
        end
        valid_q <= p_vld_q;
        if (p_vld_q) begin
          o_q <= p_dat_q;
        end
      end
    end
  end else begin : g_out_direct
    always_ff @(posedge CE or negedge RSTB) begin
      if (!RSTB) begin
        o_q     <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_en;
        if (rd_en) begin
          o_q <= rd_word;
        end
      end
    end
  end

  assign O     = o_q;
  assign VALID = valid_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_sram1rw_mwp.sv
// Bench for sram1rw_mwp: three instances (default, OUT_REG=1, DEPTH=100)
// checked cycle by cycle against a reference model through an expectation queue.
module tb_sram1rw_mwp;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rstb, csb, web, oeb;
  logic [6:0]  a;
  logic [47:0] din;
  logic [5:0]  wm;

  logic [47:0] o_w [NI];
  logic        v_w [NI];
  logic        b_w [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram1rw_mwp dut0 (
    .CE(clk), .RSTB(rstb), .CSB(csb), .WEB(web), .OEB(oeb), .A(a), .I(din),
    .WMASK(wm), .O(o_w[0]), .VALID(v_w[0]), .BUSY(b_w[0])
  );
  sram1rw_mwp #(.OUT_REG(1)) dut1 (
    .CE(clk), .RSTB(rstb), .CSB(csb), .WEB(web), .OEB(oeb), .A(a), .I(din),
    .WMASK(wm), .O(o_w[1]), .VALID(v_w[1]), .BUSY(b_w[1])
  );
  sram1rw_mwp #(.DEPTH(100)) dut2 (
    .CE(clk), .RSTB(rstb), .CSB(csb), .WEB(web), .OEB(oeb), .A(a), .I(din),
    .WMASK(wm), .O(o_w[2]), .VALID(v_w[2]), .BUSY(b_w[2])
  );

  // Reference model state
  logic [47:0] mm [NI][128];
  int          cnt  [NI];
  bit          busy [NI];
  logic [47:0] lo   [NI];
  bit          pv   [NI];
  logic [47:0] pd   [NI];

  typedef struct {
    logic [47:0] o;
    logic        v;
    logic        b;
  } exp_t;
  exp_t sbq [$];

  typedef struct {
    logic        csb, web, oeb;
    logic [6:0]  a;
    logic [47:0] i;
    logic [5:0]  wm;
    logic [47:0] eo;
    logic        ev;
  } vec_t;
  vec_t tbl [13];

  function automatic int dep(int k);
    return (k == 2) ? 100 : 128;
  endfunction

  task automatic chk(string nm, logic [47:0] act, logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < NI; k++) begin
      cnt[k] = 0; busy[k] = 1'b1; lo[k] = '0; pv[k] = 1'b0; pd[k] = '0;
    end
  endtask

  task automatic drv(logic c, logic w, logic r, logic [6:0] ad, logic [47:0] d, logic [5:0] m);
    csb = c; web = w; oeb = r; a = ad; din = d; wm = m;
  endtask

  task automatic rnd();
    csb = ($urandom_range(0, 3) == 0);
    web = 1'($urandom_range(0, 1));
    oeb = 1'($urandom_range(0, 1));
    a   = 7'($urandom_range(0, 127));
    din = 48'({$urandom(), $urandom()});
    wm  = 6'($urandom());
  endtask

  // Push the model's prediction for this edge, then compare after the edge
  task automatic step();
    exp_t        e;
    logic        re, we;
    logic [47:0] rd;
    re = !csb && !oeb;
    we = !csb && !web;
    for (int k = 0; k < NI; k++) begin
      e.v = 1'b0;
      if (!rstb) begin
        cnt[k] = 0; busy[k] = 1'b1; lo[k] = '0; pv[k] = 1'b0; pd[k] = '0;
      end else if (busy[k]) begin
        mm[k][cnt[k]] = '0;
        cnt[k]++;
        if (cnt[k] == dep(k)) busy[k] = 1'b0;
        pv[k] = 1'b0;
      end else begin
        rd = (int'(a) < dep(k)) ? mm[k][a] : 48'h0;
        if (we && int'(a) < dep(k)) begin
          for (int g = 0; g < 6; g++) begin
            if (wm[g]) mm[k][a][g*8 +: 8] = din[g*8 +: 8];
          end
        end
        if (k == 1) begin
          e.v = pv[k];
          if (pv[k]) lo[k] = pd[k];
          pv[k] = re;
          pd[k] = rd;
        end else begin
          e.v = re;
          if (re) lo[k] = rd;
        end
      end
      e.o = lo[k];
      e.b = busy[k];
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      e = sbq.pop_front();
      chk($sformatf("sb_o%0d", k), o_w[k], e.o);
      chk($sformatf("sb_valid%0d", k), 48'(v_w[k]), 48'(e.v));
      chk($sformatf("sb_busy%0d", k), 48'(b_w[k]), 48'(e.b));
    end
  endtask

  // Asynchronous assertion: outputs must clear without waiting for an edge
  task automatic assert_rst(string nm);
    rstb = 1'b0;
    #1;
    mreset();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_o%0d", nm, k), o_w[k], 48'h0);
      chk($sformatf("%s_valid%0d", nm, k), 48'(v_w[k]), 48'h0);
      chk($sformatf("%s_busy%0d", nm, k), 48'(b_w[k]), 48'h1);
    end
  endtask

  task automatic fill_wait(string nm);
    int n, n2;
    n = 0; n2 = 0;
    do begin
      rnd();
      step();
      n++;
      if (n2 == 0 && !b_w[2]) n2 = n;
    end while (b_w[0] && n < 300);
    chk({nm, "_len128"}, 48'(n), 48'd128);
    chk({nm, "_len100"}, 48'(n2), 48'd100);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 7'd5,   48'hFFFF_FFFF_FFFF, 6'h3F, 48'h0,             1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 7'd5,   48'h0,              6'h05, 48'h0,             1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 7'd5,   48'h0,              6'h00, 48'hFFFF_FF00_FF00, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 7'd5,   48'h0,              6'h00, 48'hFFFF_FF00_FF00, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 7'd9,   48'h123,            6'h3F, 48'hFFFF_FF00_FF00, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 7'd9,   48'h456,            6'h3F, 48'h123,           1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 7'd9,   48'h0,              6'h00, 48'h456,           1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 7'd110, 48'hABC,            6'h3F, 48'h456,           1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 7'd110, 48'h0,              6'h00, 48'hABC,           1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 7'd9,   48'hFFF,            6'h3F, 48'hABC,           1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 7'd9,   48'h0,              6'h00, 48'h456,           1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 7'd9,   48'h0,              6'h00, 48'h456,           1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 7'd9,   48'h0,              6'h00, 48'h456,           1'b1};

    rstb = 1'b1;
    drv(1'b1, 1'b1, 1'b1, 7'd0, 48'h0, 6'h0);
    #2;
    assert_rst("rst0");
    for (int n = 0; n < 3; n++) step();
    rstb = 1'b1;
    fill_wait("fill0");

    drv(1'b1, 1'b1, 1'b1, 7'd0, 48'h0, 6'h0);
    for (int n = 0; n < 13; n++) begin
      drv(tbl[n].csb, tbl[n].web, tbl[n].oeb, tbl[n].a, tbl[n].i, tbl[n].wm);
      step();
      chk($sformatf("tbl%0d_o", n), o_w[0], tbl[n].eo);
      chk($sformatf("tbl%0d_valid", n), 48'(v_w[0]), 48'(tbl[n].ev));
      if (n == 8) begin
        chk("odd_oob_o", o_w[2], 48'h0);
        chk("odd_oob_valid", 48'(v_w[2]), 48'h1);
      end
    end

    // OUT_REG=1 back-to-back reads
    drv(1'b0, 1'b0, 1'b1, 7'd0, 48'h111, 6'h3F); step();
    drv(1'b0, 1'b0, 1'b1, 7'd1, 48'h222, 6'h3F); step();
    drv(1'b0, 1'b0, 1'b1, 7'd2, 48'h333, 6'h3F); step();
    drv(1'b0, 1'b1, 1'b0, 7'd0, 48'h0, 6'h0); step();
    chk("strm_e1_valid", 48'(v_w[1]), 48'h0);
    drv(1'b0, 1'b1, 1'b0, 7'd1, 48'h0, 6'h0); step();
    chk("strm_e2_o", o_w[1], 48'h111);
    chk("strm_e2_valid", 48'(v_w[1]), 48'h1);
    drv(1'b0, 1'b1, 1'b0, 7'd2, 48'h0, 6'h0); step();
    chk("strm_e3_o", o_w[1], 48'h222);
    chk("strm_e3_valid", 48'(v_w[1]), 48'h1);
    drv(1'b1, 1'b1, 1'b1, 7'd0, 48'h0, 6'h0); step();
    chk("strm_e4_o", o_w[1], 48'h333);
    chk("strm_e4_valid", 48'(v_w[1]), 48'h1);
    step();
    chk("strm_e5_o", o_w[1], 48'h333);
    chk("strm_e5_valid", 48'(v_w[1]), 48'h0);

    for (int n = 0; n < 150; n++) begin
      rnd();
      step();
    end

    // Reset during RUN with a read still in the OUT_REG pipe
    drv(1'b0, 1'b1, 1'b0, 7'd1, 48'h0, 6'h0);
    step();
    assert_rst("rst_run");
    for (int n = 0; n < 2; n++) step();
    rstb = 1'b1;
    for (int n = 0; n < 50; n++) begin
      rnd();
      step();
    end
    assert_rst("rst_fill");
    step();
    rstb = 1'b1;
    fill_wait("fill1");

    for (int n = 0; n < 128; n++) begin
      drv(1'b0, 1'b1, 1'b0, 7'(n), 48'h0, 6'h0);
      step();
    end
    drv(1'b1, 1'b1, 1'b1, 7'd0, 48'h0, 6'h0);
    step();
    step();

    // Out-of-range access on the DEPTH=100 instance
    drv(1'b0, 1'b0, 1'b1, 7'd110, 48'hFFFF_FFFF_FFFF, 6'h3F); step();
    drv(1'b0, 1'b1, 1'b0, 7'd110, 48'h0, 6'h0); step();
    chk("odd_rd110_o", o_w[2], 48'h0);
    chk("odd_rd110_valid", 48'(v_w[2]), 48'h1);
    for (int n = 0; n < 100; n++) begin
      drv(1'b0, 1'b1, 1'b0, 7'(n), 48'h0, 6'h0);
      step();
    end
    drv(1'b1, 1'b1, 1'b1, 7'd0, 48'h0, 6'h0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
